rectangle_skeygen_dual: RTL
===========================

Name: rectangle_skeygen_dual

Overview:
- Parametrised RECTANGLE key-schedule engine that supports both key sizes: 80-bit (5×16 rows) and 128-bit (4×32 rows), chosen per run by `KeySel`.
- Runs on a Start/Ready/Done handshake instead of a free-running counter.
- Streams one 64-bit subkey per cycle into the local subkey memory through a write port plus a one-cycle flush pulse.
- Round constants come from an internal 5-bit LFSR rather than a lookup.

Parameters:
- NUM_SUBKEYS, 26, number of subkeys written per run (legal 1..26; 26 = 25 rounds + whitening).
- ADDR_W, 5, width of WAddr; must satisfy 2^ADDR_W >= NUM_SUBKEYS.

Ports:
- Clk  input  1  clock, rising edge.
- RstN  input  1  reset, asynchronous, active-low.
- Start  input  1  request a new schedule; sampled only when Ready=1.
- KeySel  input  1  0 = 80-bit key, 1 = 128-bit key; latched with Start.
- Key  input  128  master key; 80-bit mode uses Key[79:0] and ignores Key[127:80].
- Ready  output  1  high in IDLE.
- Busy  output  1  high in RUN.
- Done  output  1  one-cycle pulse after the last write.
- flush  output  1  one-cycle pulse; memory clear strobe for a new key.
- WE  output  1  subkey write enable.
- WAddr  output  ADDR_W  subkey index 0..NUM_SUBKEYS-1.
- KeyIn  output  64  subkey write data.

Behaviour:
- Reset (asynchronous, any time, including mid-run):
  - State goes to IDLE; key rows, counter and LFSR clear to 0.
  - Outputs: Ready=1; Busy, Done, flush and WE = 0; WAddr = 0; KeyIn = 0.
- States: IDLE → RUN → DONE → IDLE.
- IDLE, with Start=1 at edge k:
  - Load key rows.
  - Latch KeySel into `mode`.
  - Set cnt = 0 and rc = 5'h01.
  - Go to RUN.
  - Start with Ready=0 is ignored, not queued.
- Row load:
  - 128-bit mode: r0 = Key[31:0], r1 = Key[63:32], r2 = Key[95:64], r3 = Key[127:96].
  - 80-bit mode: r0..r4 = Key[15:0], [31:16], [47:32], [63:48], [79:64].
- RUN, each cycle:
  - WE = 1 and WAddr = cnt. flush = 1 only in the first RUN cycle (cnt = 0).
  - KeyIn in 128-bit mode = {r3[15:0], r2[15:0], r1[15:0], r0[15:0]}.
  - KeyIn in 80-bit mode = {r3, r2, r1, r0}.
  - At the edge, rows update by one schedule round using the current rc; then rc advances and cnt increments.
  - When cnt = NUM_SUBKEYS-1, the next state is DONE.
- DONE: Done = 1 and WE = 0 for one cycle, then IDLE.
- Timing: Start accepted at edge k → writes in cycles k+1 .. k+NUM_SUBKEYS → Done in cycle k+NUM_SUBKEYS+1 → Ready in cycle k+NUM_SUBKEYS+2.
- Schedule round, 128-bit mode:
  - S-box (standard RECTANGLE S, S(0)=6) applied to columns 0..7. Column j input = {r3[j], r2[j], r1[j], r0[j]}; output bit i is written back to ri[j].
  - r0' = rotl8(r0) ^ r1, r1' = r2, r2' = rotl16(r2) ^ r3, r3' = r0.
  - r0'[4:0] ^= rc.
- Schedule round, 80-bit mode:
  - S-box applied to columns 0..3 of r0..r3.
  - r0' = rotl8(r0) ^ r1, r1' = r2, r2' = r3, r3' = rotl12(r3) ^ r4, r4' = r0.
  - r0'[4:0] ^= rc.
  - Only the low 16 bits of the row registers are used; the upper bits are held at 0.
- LFSR:
  - rc_next = {rc[3:0], rc[4]^rc[2]}.
  - Sequence: 01, 02, 04, 09, 12, 05, 0B, 16, 0C, 19, 13, 07, 0F, 1F, 1E, 1C, 18, 11, 03, 06, 0D, 1B, 17, 0E, 1D.
- NUM_SUBKEYS = 1: a single write of the unmodified key rows, then DONE.
- Key and KeySel may change freely after acceptance and have no effect until the next accepted Start.

Test Plan:
- 128-bit zero key:
  - Stimulus: Start, KeySel=1, Key=0.
  - Required: WAddr0 = 0000_0000_0000_0000, WAddr1 = 0000_0000_00FF_00FE; 26 writes; Done at cycle 27 after the accepting edge; flush only with WAddr0.
- 80-bit zero key:
  - Stimulus: Start, KeySel=0, Key=0.
  - Required: WAddr0 = 0, WAddr1 = 0000_0000_000F_000E; Key[127:80] = all-ones gives identical output.
- Golden model:
  - Stimulus: random keys in both modes.
  - Required: all 26 subkeys match the C/Python reference schedule, and rc per round matches the listed sequence.
- Handshake:
  - Stimulus: pulse Start again at cycles 3 and 27 of a run.
  - Required: both ignored and the write stream is unchanged; a Start issued when Ready=1 is accepted and flush pulses again.
- Reset mid-run:
  - Stimulus: deassert RstN at WAddr = 10.
  - Required: WE, Busy and Done drop immediately and Ready = 1; the next run starts again at WAddr 0 with rc = 01.
- Parameter sweep:
  - Stimulus: NUM_SUBKEYS = 1 and 8, ADDR_W = 3.
  - Required: exactly 1 or 8 writes, addresses 0..N-1, Done one cycle after the last write.

Source files
------------

// File: rtl/rectangle_skeygen_dual.sv
// RECTANGLE key schedule for 80/128-bit keys: one 64-bit subkey per cycle after an accepted Start.
// Latency: first write one cycle after acceptance, Done one cycle after the last write; no backpressure.
module rectangle_skeygen_dual #(
    parameter int NUM_SUBKEYS = 26,
    parameter int ADDR_W      = 5
) (
    input  logic              Clk,
    input  logic              RstN,
    input  logic              Start,
    input  logic              KeySel,
    input  logic [127:0]      Key,
    output logic              Ready,
    output logic              Busy,
    output logic              Done,
    output logic              flush,
    output logic              WE,
    output logic [ADDR_W-1:0] WAddr,
    output logic [63:0]       KeyIn
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_SUBKEYS - 1);

    logic [1:0]        state_q, state_d;
    logic              mode_q, mode_d;
    logic [31:0]       r0_q, r1_q, r2_q, r3_q;
    logic [31:0]       r0_d, r1_d, r2_d, r3_d;
    logic [15:0]       r4_q, r4_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [4:0]        rc_q, rc_d;

    logic [31:0]       s0, s1, s2, s3;
    logic [31:0]       r0_n, r1_n, r2_n, r3_n;
    logic [15:0]       r4_n;
    logic [3:0]        col, sc;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h6;
            4'h1: y = 4'h5;
            4'h2: y = 4'hC;
            4'h3: y = 4'hA;
            4'h4: y = 4'h1;
            4'h5: y = 4'hE;
            4'h6: y = 4'h7;
            4'h7: y = 4'h9;
            4'h8: y = 4'hB;
            4'h9: y = 4'h0;
            4'hA: y = 4'h3;
            4'hB: y = 4'hD;
            4'hC: y = 4'h8;
            4'hD: y = 4'hF;
            4'hE: y = 4'h4;
            default: y = 4'h2;
        endcase
        return y;
    endfunction

    // One schedule round on the current rows; 80-bit mode only touches columns 0..3
    // so the zero upper halves of the rows never feed the S-box.
    always_comb begin
        s0  = r0_q;
        s1  = r1_q;
        s2  = r2_q;
        s3  = r3_q;
        col = 4'h0;
        sc  = 4'h0;
        for (int j = 0; j < 8; j++) begin
            if (mode_q || (j < 4)) begin
                col   = {r3_q[j], r2_q[j], r1_q[j], r0_q[j]};
                sc    = sbox(col);
                s0[j] = sc[0];
                s1[j] = sc[1];
                s2[j] = sc[2];
                s3[j] = sc[3];
            end
        end
        if (mode_q) begin
            r0_n = {s0[23:0], s0[31:24]} ^ s1;
            r1_n = s2;
            r2_n = {s2[15:0], s2[31:16]} ^ s3;
            r3_n = s0;
            r4_n = 16'h0;
        end else begin
            r0_n = {16'h0, s0[7:0], s0[15:8]} ^ {16'h0, s1[15:0]};
            r1_n = {16'h0, s2[15:0]};
            r2_n = {16'h0, s3[15:0]};
            r3_n = {16'h0, s3[3:0], s3[15:4]} ^ {16'h0, r4_q};
            r4_n = s0[15:0];
        end
        r0_n[4:0] = r0_n[4:0] ^ rc_q;
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        r0_d    = r0_q;
        r1_d    = r1_q;
        r2_d    = r2_q;
        r3_d    = r3_q;
        r4_d    = r4_q;
        cnt_d   = cnt_q;
        rc_d    = rc_q;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    mode_d  = KeySel;
                    cnt_d   = '0;
                    rc_d    = 5'h01;
                    state_d = S_RUN;
                    if (KeySel) begin
                        r0_d = Key[31:0];
                        r1_d = Key[63:32];
                        r2_d = Key[95:64];
                        r3_d = Key[127:96];
                        r4_d = 16'h0;
                    end else begin
                        r0_d = {16'h0, Key[15:0]};
                        r1_d = {16'h0, Key[31:16]};
                        r2_d = {16'h0, Key[47:32]};
                        r3_d = {16'h0, Key[63:48]};
                        r4_d = Key[79:64];
                    end
                end
            end
            S_RUN: begin
                r0_d  = r0_n;
                r1_d  = r1_n;
                r2_d  = r2_n;
                r3_d  = r3_n;
                r4_d  = r4_n;
                rc_d  = {rc_q[3:0], rc_q[4] ^ rc_q[2]};
                cnt_d = cnt_q + ADDR_W'(1);
                if (cnt_q == LAST_IDX) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            r0_q    <= '0;
            r1_q    <= '0;
            r2_q    <= '0;
            r3_q    <= '0;
            r4_q    <= '0;
            cnt_q   <= '0;
            rc_q    <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            r0_q    <= r0_d;
            r1_q    <= r1_d;
            r2_q    <= r2_d;
            r3_q    <= r3_d;
            r4_q    <= r4_d;
            cnt_q   <= cnt_d;
            rc_q    <= rc_d;
        end
    end

    // Both key sizes expose the low 16 bits of rows 0..3 as the subkey.
    assign Ready = (state_q == S_IDLE);
    assign Busy  = (state_q == S_RUN);
    assign Done  = (state_q == S_DONE);
    assign WE    = Busy;
    assign flush = Busy && (cnt_q == '0);
    assign WAddr = Busy ? cnt_q : '0;
    assign KeyIn = Busy ? {r3_q[15:0], r2_q[15:0], r1_q[15:0], r0_q[15:0]} : 64'h0;

endmodule
